// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared states, counter width and reset values for the scan-code debounce block
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    localparam int CNT_W = 4;

    localparam scan_state_t      RST_STATE = IDLE;
    localparam logic [CNT_W-1:0] RST_CNT   = '0;
    localparam logic             RST_FLAG  = 1'b0;

    // Saturating 4-bit increment; the counters must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/scan_cmp_bit.sv
// rtl/scan_cmp_bit.sv - one stored scan-code bit, loaded on enp&ld, with its XOR compare
module scan_cmp_bit
    import scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_ld,
    input  logic i_d,
    output logic o_q,
    output logic o_c
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RST_FLAG;
        end else if (i_en && i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
    assign o_c = r_q ^ i_d;

endmodule

// File: rtl/scan_code_debounce.sv
// rtl/scan_code_debounce.sv - scan-code compare latch with debounce/hold FSM; SCAN_OVERRUN_EN adds ack/overrun
module scan_code_debounce
    import scan_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int MATCH_CNT   = 2,
    parameter int RELEASE_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enp,
    input  logic [WIDTH-1:0] D,
    input  logic             key_dn,
    input  logic             Ld,
`ifdef SCAN_OVERRUN_EN
    input  logic             ack,
    output logic             overrun,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] C,
    output logic             match,
    output logic             code_valid,
    output logic             key_held
);

    localparam logic [CNT_W-1:0] MATCH_TGT   = CNT_W'(MATCH_CNT);
    localparam logic [CNT_W-1:0] RELEASE_TGT = CNT_W'(RELEASE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_mcnt;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_mcnt_nxt;
    logic [CNT_W-1:0] w_rcnt_nxt;
    logic [CNT_W-1:0] w_mcnt_inc;
    logic [CNT_W-1:0] w_rcnt_inc;
    logic             r_code_valid;
    logic             r_key_held;
    logic             w_cv_nxt;
    logic             w_held_nxt;
    logic             w_load;
    logic             w_match;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            scan_cmp_bit u_bit (
                .clk   (clk),
                .reset (reset),
                .i_en  (enp),
                .i_ld  (w_load),
                .i_d   (D[gi]),
                .o_q   (Q[gi]),
                .o_c   (C[gi])
            );
        end
    endgenerate

    assign w_match    = (C == '0);
    assign w_mcnt_inc = sat_inc(r_mcnt);
    assign w_rcnt_inc = sat_inc(r_rcnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RST_STATE;
            r_mcnt       <= RST_CNT;
            r_rcnt       <= RST_CNT;
            r_code_valid <= RST_FLAG;
            r_key_held   <= RST_FLAG;
        end else begin
            r_state      <= w_state_nxt;
            r_mcnt       <= w_mcnt_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_code_valid <= w_cv_nxt;
            r_key_held   <= w_held_nxt;
        end
    end

    // Everything holds without enp, except code_valid which self-clears.
    always_comb begin
        w_state_nxt = r_state;
        w_mcnt_nxt  = r_mcnt;
        w_rcnt_nxt  = r_rcnt;
        w_held_nxt  = r_key_held;
        w_cv_nxt    = 1'b0;
        w_load      = 1'b0;
        if (enp) begin
            case (r_state)
                IDLE: begin
                    if (key_dn && Ld) begin
                        w_load      = 1'b1;
                        w_mcnt_nxt  = CNT_ONE;
                        w_state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (key_dn && w_match) begin
                        w_mcnt_nxt = w_mcnt_inc;
                        if (w_mcnt_inc == MATCH_TGT) begin
                            w_cv_nxt    = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_rcnt_nxt  = RST_CNT;
                            w_state_nxt = HELD;
                        end
                    end else if (key_dn && Ld) begin
                        w_load     = 1'b1;
                        w_mcnt_nxt = CNT_ONE;
                    end else begin
                        w_mcnt_nxt  = RST_CNT;
                        w_state_nxt = IDLE;
                    end
                end
                HELD: begin
                    // A different key while held only counts towards release.
                    if (key_dn && w_match) begin
                        w_rcnt_nxt = RST_CNT;
                    end else begin
                        w_rcnt_nxt = w_rcnt_inc;
                        if (w_rcnt_inc == RELEASE_TGT) begin
                            w_held_nxt  = 1'b0;
                            w_mcnt_nxt  = RST_CNT;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign match      = w_match;
    assign code_valid = r_code_valid;
    assign key_held   = r_key_held;

`ifdef SCAN_OVERRUN_EN
    logic r_pending;
    logic r_overrun;

    // An ack arriving with a new code keeps it pending and is not an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= RST_FLAG;
            r_overrun <= RST_FLAG;
        end else begin
            if (r_code_valid) begin
                r_pending <= 1'b1;
            end else if (ack) begin
                r_pending <= 1'b0;
            end
            if (ack) begin
                r_overrun <= 1'b0;
            end else if (r_code_valid && r_pending) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_scan_code_debounce.sv
// tb/tb_scan_code_debounce.sv - table-driven self-checking bench for scan_code_debounce
module tb_scan_code_debounce;

    logic       clk;
    logic       reset;
    logic       enp;
    logic [5:0] D;
    logic       key_dn;
    logic       Ld;
    logic [5:0] Q;
    logic [5:0] C;
    logic       match;
    logic       code_valid;
    logic       key_held;
`ifdef SCAN_OVERRUN_EN
    logic       ack;
    logic       overrun;
`endif

    int checks;
    int failures;

    scan_code_debounce #(.WIDTH(6), .MATCH_CNT(2), .RELEASE_CNT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .enp        (enp),
        .D          (D),
        .key_dn     (key_dn),
        .Ld         (Ld),
`ifdef SCAN_OVERRUN_EN
        .ack        (ack),
        .overrun    (overrun),
`endif
        .Q          (Q),
        .C          (C),
        .match      (match),
        .code_valid (code_valid),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic       k;
        logic       l;
        logic [5:0] d;
        logic [5:0] q;
        logic       cv;
        logic       held;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e, input logic k, input logic l, input logic [5:0] d,
                       input logic [5:0] q, input logic cv, input logic held);
        vec_t v;
        v.e = e; v.k = k; v.l = l; v.d = d; v.q = q; v.cv = cv; v.held = held;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic scan(input logic e, input logic k, input logic l, input logic [5:0] d);
        @(negedge clk);
        enp = e; key_dn = k; Ld = l; D = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [5:0] q, input logic [5:0] d,
                              input logic cv, input logic held);
        logic [5:0] c_exp;
        c_exp = q ^ d;
        check({tag, ".Q"}, 32'(Q), 32'(q));
        check({tag, ".C"}, 32'(C), 32'(c_exp));
        check({tag, ".match"}, 32'(match), 32'(c_exp == 6'h00));
        check({tag, ".code_valid"}, 32'(code_valid), 32'(cv));
        check({tag, ".key_held"}, 32'(key_held), 32'(held));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; enp = 1'b0; key_dn = 1'b0; Ld = 1'b0; D = 6'h00;
`ifdef SCAN_OVERRUN_EN
        ack = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("reset", 6'h00, 6'h00, 1'b0, 1'b0);

        // clean accept, enp gating, release with a matching scan in between
        add(1, 1, 1, 6'h15, 6'h15, 0, 0);
        add(1, 1, 1, 6'h15, 6'h15, 1, 1);
        add(0, 0, 0, 6'h15, 6'h15, 0, 1);
        add(1, 0, 0, 6'h15, 6'h15, 0, 1);
        add(1, 1, 0, 6'h15, 6'h15, 0, 1);
        add(1, 0, 0, 6'h15, 6'h15, 0, 1);
        add(1, 0, 0, 6'h15, 6'h15, 0, 0);
        // bounce: reload to 16, accept on third scan
        add(1, 1, 1, 6'h15, 6'h15, 0, 0);
        add(1, 1, 1, 6'h16, 6'h16, 0, 0);
        add(1, 1, 1, 6'h16, 6'h16, 1, 1);
        add(1, 0, 0, 6'h16, 6'h16, 0, 1);
        add(1, 0, 0, 6'h16, 6'h16, 0, 0);
        // second key ignored while held
        add(1, 1, 1, 6'h15, 6'h15, 0, 0);
        add(1, 1, 1, 6'h15, 6'h15, 1, 1);
        add(1, 1, 1, 6'h3F, 6'h15, 0, 1);
        add(1, 1, 1, 6'h3F, 6'h15, 0, 0);
        // IDLE without Ld, key lift in DEBOUNCE, enp=0 pause in DEBOUNCE
        add(1, 1, 0, 6'h3F, 6'h15, 0, 0);
        add(1, 1, 1, 6'h3F, 6'h3F, 0, 0);
        add(1, 0, 0, 6'h3F, 6'h3F, 0, 0);
        add(1, 1, 1, 6'h3F, 6'h3F, 0, 0);
        add(0, 1, 1, 6'h3F, 6'h3F, 0, 0);
        add(1, 1, 1, 6'h3F, 6'h3F, 1, 1);

        for (int i = 0; i < vq.size(); i++) begin
            scan(vq[i].e, vq[i].k, vq[i].l, vq[i].d);
            check_outs($sformatf("vec%0d", i), vq[i].q, vq[i].d, vq[i].cv, vq[i].held);
        end

        // asynchronous reset mid-cycle right after acceptance of 2A
        do_reset();
        scan(1, 1, 1, 6'h2A);
        scan(1, 1, 1, 6'h2A);
        check_outs("pre_async", 6'h2A, 6'h2A, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_rst", 6'h00, 6'h2A, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // reset on the accepting edge wins
        scan(1, 1, 1, 6'h2A);
        @(negedge clk);
        enp = 1'b1; key_dn = 1'b1; Ld = 1'b1; D = 6'h2A;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outs("rst_wins", 6'h00, 6'h2A, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // glitching key reloads every scan and never accepts
        for (int i = 0; i < 4; i++) begin
            logic [5:0] dg;
            dg = i[0] ? 6'h16 : 6'h15;
            scan(1, 1, 1, dg);
            check_outs($sformatf("glitch%0d", i), dg, dg, 1'b0, 1'b0);
        end

`ifdef SCAN_OVERRUN_EN
        do_reset();
        check("ovr_reset", 32'(overrun), 32'd0);
        scan(1, 1, 1, 6'h15);
        scan(1, 1, 1, 6'h15);
        scan(1, 0, 0, 6'h15);
        check("ovr_first", 32'(overrun), 32'd0);
        scan(1, 0, 0, 6'h15);
        scan(1, 1, 1, 6'h15);
        scan(1, 1, 1, 6'h15);
        scan(0, 0, 0, 6'h15);
        check("ovr_set", 32'(overrun), 32'd1);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_ack", 32'(overrun), 32'd0);
        check("pending_ack", 32'(dut.r_pending), 32'd0);
        @(negedge clk);
        ack = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
